// File: rtl/word_wr_ser_if.sv
// rtl/word_wr_ser_if.sv - store request and byte write bus bundle for word_wr_ser
interface word_wr_ser_if #(
   parameter int AW = 13
);
   logic          start;
   logic [15:0]   word;
   logic [AW-1:0] addr_in;
   logic [7:0]    data;
   logic [AW-1:0] addr;
   logic          wr;
   logic          ack;
   logic          busy;
   logic          done;

   modport master (
      output start, word, addr_in, ack,
      input  data, addr, wr, busy, done
   );

   modport slave (
      input  start, word, addr_in, ack,
      output data, addr, wr, busy, done
   );
endinterface

// File: rtl/word_wr_ser.sv
// rtl/word_wr_ser.sv - writes one 16-bit word as two byte writes at consecutive addresses
module word_wr_ser #(
   parameter int AW       = 13,
   parameter bit LO_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_clk,
   word_wr_ser_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FIRST  = 2'd1;
   localparam logic [1:0] S_SECOND = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state;
   logic [15:0]   word_q;
   logic [7:0]    data_q;
   logic [AW-1:0] addr_q;
   logic          wr_q;
   logic          busy_q;
   logic          done_q;

   always_ff @(posedge clk) begin
      if (rst_clk) begin
         state  <= S_IDLE;
         word_q <= 16'h0000;
         data_q <= 8'h00;
         addr_q <= '0;
         wr_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  word_q <= bus.word;
                  addr_q <= bus.addr_in;
                  data_q <= LO_FIRST ? bus.word[7:0] : bus.word[15:8];
                  wr_q   <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= S_FIRST;
               end else begin
                  data_q <= 8'h00;
                  wr_q   <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            S_FIRST: begin
               // second byte follows immediately; the address increment wraps at 2^AW
               if (bus.ack) begin
                  addr_q <= addr_q + {{(AW-1){1'b0}}, 1'b1};
                  data_q <= LO_FIRST ? word_q[15:8] : word_q[7:0];
                  state  <= S_SECOND;
               end
            end
            S_SECOND: begin
               if (bus.ack) begin
                  data_q <= 8'h00;
                  wr_q   <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               word_q <= 16'h0000;
               data_q <= 8'h00;
               addr_q <= '0;
               wr_q   <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data = data_q;
   assign bus.addr = addr_q;
   assign bus.wr   = wr_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_word_wr_ser.sv
// tb/tb_word_wr_ser.sv - directed self-checking bench for word_wr_ser
module tb_word_wr_ser;
   logic clk = 1'b0;
   logic rst_clk = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   word_wr_ser_if #(.AW(13)) bus0 ();
   word_wr_ser_if #(.AW(13)) bus1 ();

   word_wr_ser #(.AW(13), .LO_FIRST(1'b0)) dut0 (.clk(clk), .rst_clk(rst_clk), .bus(bus0));
   word_wr_ser #(.AW(13), .LO_FIRST(1'b1)) dut1 (.clk(clk), .rst_clk(rst_clk), .bus(bus1));

   always #5 clk = ~clk;

   // memory-side models: every accepted byte is logged and stored
   logic [20:0] log0[$];
   logic [20:0] log1[$];
   logic [7:0]  mem0 [0:8191];
   logic [7:0]  mem1 [0:8191];
   int          done_cnt0 = 0;

   always @(posedge clk) begin
      if (!rst_clk && bus0.wr === 1'b1 && bus0.ack === 1'b1) begin
         log0.push_back({bus0.addr, bus0.data});
         mem0[bus0.addr] = bus0.data;
      end
      if (!rst_clk && bus1.wr === 1'b1 && bus1.ack === 1'b1) begin
         log1.push_back({bus1.addr, bus1.data});
         mem1[bus1.addr] = bus1.data;
      end
      if (!rst_clk && bus0.done === 1'b1) done_cnt0++;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start0(input logic [15:0] w, input logic [12:0] a);
      bus0.start = 1'b1; bus0.word = w; bus0.addr_in = a;
      step();
      bus0.start = 1'b0; bus0.word = 16'hFFFF; bus0.addr_in = 13'h1ABC;
   endtask

   task automatic test_reset();
      rst_clk = 1'b1;
      step(); step();
      rst_clk = 1'b0;
      n_cmp++; if (bus0.wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %0h want 0", bus0.wr); end
      n_cmp++; if (bus0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0h want 0", bus0.busy); end
      n_cmp++; if (bus0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0h want 0", bus0.done); end
      n_cmp++; if (bus0.data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h want 00", bus0.data); end
      n_cmp++; if (bus0.addr !== 13'h0000) begin n_bad++; $display("FAIL reset_addr: got %0h want 0000", bus0.addr); end
   endtask

   task automatic test_basic();
      log0.delete(); done_cnt0 = 0; bus0.ack = 1'b1;
      start0(16'h12AB, 13'h0100);
      n_cmp++; if ({bus0.wr, bus0.busy, bus0.addr, bus0.data} !== {1'b1, 1'b1, 13'h0100, 8'h12}) begin
         n_bad++; $display("FAIL basic_first: got wr=%0h busy=%0h addr=%0h data=%0h want 1 1 0100 12", bus0.wr, bus0.busy, bus0.addr, bus0.data); end
      step();
      n_cmp++; if ({bus0.wr, bus0.done, bus0.addr, bus0.data} !== {1'b1, 1'b0, 13'h0101, 8'hAB}) begin
         n_bad++; $display("FAIL basic_second: got wr=%0h done=%0h addr=%0h data=%0h want 1 0 0101 AB", bus0.wr, bus0.done, bus0.addr, bus0.data); end
      step();
      n_cmp++; if ({bus0.wr, bus0.done, bus0.busy, bus0.data} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
         n_bad++; $display("FAIL basic_done: got wr=%0h done=%0h busy=%0h data=%0h want 0 1 1 00", bus0.wr, bus0.done, bus0.busy, bus0.data); end
      step();
      n_cmp++; if ({bus0.done, bus0.busy} !== 2'b00) begin
         n_bad++; $display("FAIL basic_idle: got done=%0h busy=%0h want 0 0", bus0.done, bus0.busy); end
      n_cmp++; if (log0.size() != 2 || log0[0] !== {13'h0100, 8'h12} || log0[1] !== {13'h0101, 8'hAB}) begin
         n_bad++; $display("FAIL basic_log: got %0d writes want 2 (0100,12),(0101,AB)", log0.size()); end
      n_cmp++; if ({mem0[13'h0100], mem0[13'h0101]} !== 16'h12AB) begin
         n_bad++; $display("FAIL basic_ram: got %0h want 12AB", {mem0[13'h0100], mem0[13'h0101]}); end
      n_cmp++; if (done_cnt0 != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt0); end
   endtask

   task automatic test_wait();
      log0.delete(); done_cnt0 = 0; bus0.ack = 1'b1;
      start0(16'h12AB, 13'h0100);
      bus0.ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if ({bus0.wr, bus0.addr, bus0.data} !== {1'b1, 13'h0100, 8'h12}) begin
            n_bad++; $display("FAIL wait_first_%0d: got wr=%0h addr=%0h data=%0h want 1 0100 12", i, bus0.wr, bus0.addr, bus0.data); end
      end
      bus0.ack = 1'b1; step(); bus0.ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if ({bus0.wr, bus0.addr, bus0.data} !== {1'b1, 13'h0101, 8'hAB}) begin
            n_bad++; $display("FAIL wait_second_%0d: got wr=%0h addr=%0h data=%0h want 1 0101 AB", i, bus0.wr, bus0.addr, bus0.data); end
      end
      bus0.ack = 1'b1; step(); step(); step();
      n_cmp++; if (log0.size() != 2 || log0[0] !== {13'h0100, 8'h12} || log0[1] !== {13'h0101, 8'hAB}) begin
         n_bad++; $display("FAIL wait_log: got %0d writes want 2", log0.size()); end
      n_cmp++; if (done_cnt0 != 1) begin n_bad++; $display("FAIL wait_done_cnt: got %0d want 1", done_cnt0); end
   endtask

   task automatic test_wrap();
      log0.delete(); bus0.ack = 1'b1;
      start0(16'hBEEF, 13'h1FFF);
      step(); step(); step();
      n_cmp++; if (log0.size() != 2 || log0[0] !== {13'h1FFF, 8'hBE} || log0[1] !== {13'h0000, 8'hEF}) begin
         n_bad++; $display("FAIL wrap_log: got %0d writes first=%0h second=%0h want (1FFF,BE),(0000,EF)", log0.size(), log0[0], log0[1]); end
   endtask

   task automatic test_back_to_back();
      log0.delete(); bus0.ack = 1'b1;
      start0(16'h1234, 13'h0300);
      bus0.start = 1'b1; bus0.word = 16'h9999; bus0.addr_in = 13'h0700;
      step(); step(); step();
      n_cmp++; if ({bus0.busy, bus0.wr} !== 2'b00) begin
         n_bad++; $display("FAIL busy_fall: got busy=%0h wr=%0h want 0 0", bus0.busy, bus0.wr); end
      bus0.word = 16'h5A3C; bus0.addr_in = 13'h0040;
      step();
      bus0.start = 1'b0;
      n_cmp++; if ({bus0.wr, bus0.busy, bus0.addr, bus0.data} !== {1'b1, 1'b1, 13'h0040, 8'h5A}) begin
         n_bad++; $display("FAIL restart_first: got wr=%0h busy=%0h addr=%0h data=%0h want 1 1 0040 5A", bus0.wr, bus0.busy, bus0.addr, bus0.data); end
      step(); step(); step();
      n_cmp++; if (log0.size() != 4 || log0[0] !== {13'h0300, 8'h12} || log0[1] !== {13'h0301, 8'h34}
                   || log0[2] !== {13'h0040, 8'h5A} || log0[3] !== {13'h0041, 8'h3C}) begin
         n_bad++; $display("FAIL busy_ignore_log: got %0d writes want 4 (0300,12),(0301,34),(0040,5A),(0041,3C)", log0.size()); end
   endtask

   task automatic test_lo_first();
      log1.delete(); bus1.ack = 1'b1;
      bus1.start = 1'b1; bus1.word = 16'hC3D4; bus1.addr_in = 13'h0020;
      step();
      bus1.start = 1'b0; bus1.word = 16'h0000;
      n_cmp++; if ({bus1.addr, bus1.data} !== {13'h0020, 8'hD4}) begin
         n_bad++; $display("FAIL lo_first_byte: got addr=%0h data=%0h want 0020 D4", bus1.addr, bus1.data); end
      step(); step(); step();
      n_cmp++; if (log1.size() != 2 || log1[0] !== {13'h0020, 8'hD4} || log1[1] !== {13'h0021, 8'hC3}) begin
         n_bad++; $display("FAIL lo_first_log: got %0d writes want (0020,D4),(0021,C3)", log1.size()); end
      n_cmp++; if ({mem1[13'h0021], mem1[13'h0020]} !== 16'hC3D4) begin
         n_bad++; $display("FAIL lo_first_fetch: got %0h want C3D4", {mem1[13'h0021], mem1[13'h0020]}); end
   endtask

   task automatic test_reset_mid();
      int n;
      log0.delete(); done_cnt0 = 0; bus0.ack = 1'b1;
      start0(16'hA55A, 13'h0500);
      step();
      bus0.ack = 1'b0;
      step();
      rst_clk = 1'b1; step(); step(); rst_clk = 1'b0;
      n_cmp++; if ({bus0.wr, bus0.busy, bus0.done, bus0.data, bus0.addr} !== {3'b000, 8'h00, 13'h0000}) begin
         n_bad++; $display("FAIL midreset_out: got wr=%0h busy=%0h done=%0h data=%0h addr=%0h want 0 0 0 00 0000", bus0.wr, bus0.busy, bus0.done, bus0.data, bus0.addr); end
      n = log0.size();
      bus0.ack = 1'b1;
      step(); step(); step();
      n_cmp++; if (n != 1 || log0.size() != 1 || log0[0] !== {13'h0500, 8'hA5}) begin
         n_bad++; $display("FAIL midreset_log: got %0d writes want 1 (0500,A5)", log0.size()); end
      n_cmp++; if ({bus0.wr, done_cnt0 == 0} !== 2'b01) begin
         n_bad++; $display("FAIL midreset_quiet: got wr=%0h done_cnt=%0d want 0 0", bus0.wr, done_cnt0); end
   endtask

   initial begin
      bus0.start = 1'b0; bus0.word = 16'h0000; bus0.addr_in = 13'h0000; bus0.ack = 1'b0;
      bus1.start = 1'b0; bus1.word = 16'h0000; bus1.addr_in = 13'h0000; bus1.ack = 1'b0;
      test_reset();
      test_basic();
      test_wait();
      test_wrap();
      test_back_to_back();
      test_lo_first();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
